// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one flash-started 10-bit to 3-digit BCD converter across N_CH display fields.
// Define BCD_LEAD_BLANK_EN to replace leading zero digits with the 4'hF blank code at capture.
module bcd_convert_scheduler #(
  parameter int N_CH    = 4,
  parameter int CVT_LAT = 12,
  parameter int MAX_VAL = 999
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      req,
  input  logic [10*N_CH-1:0]   val,
  output logic [N_CH-1:0]      done,
  output logic [12*N_CH-1:0]   bcd_out,
  output logic [N_CH-1:0]      ovf,
  output logic                 busy,
  output logic                 cvt_flash,
  output logic [9:0]           cvt_data,
  input  logic [11:0]          cvt_result
);

  localparam int CW = $clog2(N_CH);
  localparam int LW = $clog2(CVT_LAT);

  typedef enum logic [1:0] {IDLE, FLASH, WAIT, CAPTURE} state_t;

  state_t          state;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   ch;
  logic [LW-1:0]   cnt;
  logic            lat_ovf;

  logic            gnt_found;
  logic [CW-1:0]   gnt_ch;
  logic [9:0]      gnt_raw;
  logic            gnt_ovf;
  logic [9:0]      gnt_val;
  logic [11:0]     cap_val;

  function automatic logic [11:0] blank_lead(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    if (d[11:8] == 4'h0) begin
      r[11:8] = 4'hF;
      if (d[7:4] == 4'h0) r[7:4] = 4'hF;
    end
    return r;
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    gnt_found = 1'b0;
    gnt_ch    = ptr;
    for (int i = 0; i < N_CH; i++) begin
      if (!gnt_found && req[(int'(ptr) + i) % N_CH]) begin
        gnt_found = 1'b1;
        gnt_ch    = CW'((int'(ptr) + i) % N_CH);
      end
    end
    gnt_raw = val[10*int'(gnt_ch) +: 10];
    gnt_ovf = int'(gnt_raw) > MAX_VAL;
    gnt_val = gnt_ovf ? 10'(MAX_VAL) : gnt_raw;
  end

`ifdef BCD_LEAD_BLANK_EN
  assign cap_val = blank_lead(cvt_result);
`else
  assign cap_val = cvt_result;
`endif

  // Outputs are registered on the edge entering each state, so cvt_flash is high
  // during FLASH and done/bcd_out/ovf are visible during CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      ch        <= '0;
      cnt       <= '0;
      lat_ovf   <= 1'b0;
      done      <= '0;
      bcd_out   <= '0;
      ovf       <= '0;
      busy      <= 1'b0;
      cvt_flash <= 1'b0;
      cvt_data  <= '0;
    end else begin
      // NOTE: done defaults low every cycle so it can only ever be a one-cycle pulse.
      done <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            ch        <= gnt_ch;
            lat_ovf   <= gnt_ovf;
            cvt_data  <= gnt_val;
            cvt_flash <= 1'b1;
            busy      <= 1'b1;
            state     <= FLASH;
          end
        end
        FLASH: begin
          cvt_flash <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // cvt_result is sampled CVT_LAT cycles after the flash cycle.
          if (cnt == LW'(CVT_LAT - 1)) begin
            bcd_out[12*int'(ch) +: 12] <= cap_val;
            ovf[ch]                    <= lat_ovf;
            done[ch]                   <= 1'b1;
            ptr                        <= (int'(ch) == N_CH - 1) ? '0 : ch + 1'b1;
            state                      <= CAPTURE;
          end
        end
        CAPTURE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench: converter model, transaction-level scheduler model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bcd_convert_scheduler;

  localparam int N_CH    = 4;
  localparam int CVT_LAT = 12;
  localparam int MAX_VAL = 999;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N_CH-1:0]      req = '0;
  logic [10*N_CH-1:0]   val = '0;
  logic [N_CH-1:0]      done;
  logic [12*N_CH-1:0]   bcd_out;
  logic [N_CH-1:0]      ovf;
  logic                 busy;
  logic                 cvt_flash;
  logic [9:0]           cvt_data;
  logic [11:0]          cvt_result;

  always #5 clk = ~clk;

  bcd_convert_scheduler #(.N_CH(N_CH), .CVT_LAT(CVT_LAT), .MAX_VAL(MAX_VAL)) dut (
    .clk(clk), .rst(rst), .req(req), .val(val), .done(done), .bcd_out(bcd_out),
    .ovf(ovf), .busy(busy), .cvt_flash(cvt_flash), .cvt_data(cvt_data), .cvt_result(cvt_result)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  function automatic logic [11:0] plain_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Expected stored result for a raw requested value.
  function automatic logic [11:0] expect_bcd(input int raw);
    int v, h, t, o;
    v = clamp(raw);
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
`ifdef BCD_LEAD_BLANK_EN
    if (h == 0 && t == 0) t = 15;
    if (h == 0) h = 15;
`endif
    return {4'(h), 4'(t), 4'(o)};
  endfunction

  // Converter model: result valid only from CVT_LAT cycles after flash, garbage before.
  int         cv_cnt = 0;
  logic [9:0] cv_data = '0;
  always @(posedge clk) begin
    if (cvt_flash) begin
      cv_cnt  <= 1;
      cv_data <= cvt_data;
    end else if (cv_cnt > 0 && cv_cnt < CVT_LAT) begin
      cv_cnt <= cv_cnt + 1;
    end
  end
  assign cvt_result = (cv_cnt == CVT_LAT) ? plain_bcd(int'(cv_data)) : 12'hEEE;

  // Scheduler model: phase 0 idle, 1 flash, 2..CVT_LAT+1 wait, CVT_LAT+2 capture.
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_ch    = 0;
  int          m_val   = 0;
  bit          m_pend  = 1'b0;
  int          g_ch    = 0;
  int          g_val   = 0;
  bit          rst_prev = 1'b1;
  logic [11:0] exp_bcd [N_CH];
  logic        exp_ovf [N_CH];
  logic [12*N_CH-1:0] eb;
  logic [N_CH-1:0]    eo;

  function automatic int arb(input logic [N_CH-1:0] r, input int p);
    for (int i = 0; i < N_CH; i++)
      if (r[(p + i) % N_CH]) return (p + i) % N_CH;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (rst_prev) begin
      m_phase = 0;
      m_ptr   = 0;
      for (int k = 0; k < N_CH; k++) begin
        exp_bcd[k] = '0;
        exp_ovf[k] = 1'b0;
      end
      check("rst_done", done, '0);
      check("rst_flash", cvt_flash, 0);
      check("rst_busy", busy, 0);
      check("rst_cvt_data", cvt_data, 0);
    end else begin
      if (m_phase == 0) begin
        if (m_pend) begin
          m_phase = 1;
          m_ch    = g_ch;
          m_val   = g_val;
        end
      end else if (m_phase == CVT_LAT + 2) begin
        m_phase = 0;
      end else begin
        m_phase++;
      end
      if (m_phase == CVT_LAT + 2) begin
        exp_bcd[m_ch] = expect_bcd(m_val);
        exp_ovf[m_ch] = (m_val > MAX_VAL);
        m_ptr = (m_ch + 1) % N_CH;
      end
      check("cvt_flash", cvt_flash, m_phase == 1);
      check("busy", busy, m_phase != 0);
      check("done", done, (m_phase == CVT_LAT + 2) ? (64'd1 << m_ch) : 64'd0);
      if (m_phase >= 1 && m_phase <= CVT_LAT + 1)
        check("cvt_data", cvt_data, clamp(m_val));
    end
    for (int k = 0; k < N_CH; k++) begin
      eb[12*k +: 12] = exp_bcd[k];
      eo[k]          = exp_ovf[k];
    end
    check("bcd_out", bcd_out, eb);
    check("ovf", ovf, eo);
    m_pend = !rst && m_phase == 0 && req != '0;
    if (m_pend) begin
      g_ch  = arb(req, m_ptr);
      g_val = int'(val[10*g_ch +: 10]);
    end
    rst_prev = rst;
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_val(input int k, input int v);
    val[10*k +: 10] = 10'(v);
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: no event within cycle budget @cycle %0d", name, cyc);
  endtask

  task automatic wait_flash(input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (cvt_flash) begin
        t = cyc;
        return;
      end
    end
    timeout_fail("wait_flash");
  endtask

  task automatic wait_done(input logic [N_CH-1:0] mask, input int budget, output int ch);
    ch = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((done & mask) != '0) begin
        for (int k = 0; k < N_CH; k++)
          if (done[k] && mask[k]) ch = k;
        return;
      end
    end
    timeout_fail("wait_done");
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 999;
      2:       return 1000;
      3:       return 1023;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  int t_flash, t_done, ch, n_fl;
  int ord [6];

  initial begin
    // 1: single conversion, latency and held data
    do_reset();
    set_val(0, 345);
    req = 4'b0001;
    wait_flash(50, t_flash);
    check("t1_cvt_data", cvt_data, 345);
    wait_done(4'b0001, 50, ch);
    t_done = cyc;
    req = '0;
    check("t1_latency", t_done - t_flash, CVT_LAT + 1);
    check("t1_bcd", bcd_out[11:0], 12'h345);
    check("t1_ovf", ovf[0], 0);

    // 2: all four requesting from reset, grants rotate 0..3
    do_reset();
    set_val(0, 1); set_val(1, 22); set_val(2, 333); set_val(3, 999);
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_done(req, 100, ch);
      ord[n] = ch;
      if (ch >= 0) req[ch] = 1'b0;
    end
    for (int n = 0; n < 4; n++) check("t2_order", ord[n], n);
`ifdef BCD_LEAD_BLANK_EN
    check("t2_bcd0", bcd_out[11:0], 12'hFF1);
    check("t2_bcd1", bcd_out[23:12], 12'hF22);
`else
    check("t2_bcd0", bcd_out[11:0], 12'h001);
    check("t2_bcd1", bcd_out[23:12], 12'h022);
`endif
    check("t2_bcd2", bcd_out[35:24], 12'h333);
    check("t2_bcd3", bcd_out[47:36], 12'h999);

    // 3: overflow clamp, then cleared by an in-range value
    set_val(2, 1023);
    req = 4'b0100;
    wait_flash(50, t_flash);
    check("t3_cvt_data", cvt_data, 999);
    wait_done(4'b0100, 50, ch);
    req = '0;
    check("t3_ovf_set", ovf[2], 1);
    check("t3_bcd", bcd_out[35:24], 12'h999);
    set_val(2, 5);
    req = 4'b0100;
    wait_done(4'b0100, 50, ch);
    req = '0;
    check("t3_ovf_clr", ovf[2], 0);
`ifdef BCD_LEAD_BLANK_EN
    check("t3_bcd5", bcd_out[35:24], 12'hFF5);
`else
    check("t3_bcd5", bcd_out[35:24], 12'h005);
`endif

    // 4: channels 1 and 3 held high, pointer is at 3 so grants go 3,1,3,1...
    set_val(1, 77); set_val(3, 888);
    req = 4'b1010;
    for (int n = 0; n < 6; n++) begin
      wait_done(4'b1010, 100, ch);
      ord[n] = ch;
    end
    req = '0;
    for (int n = 0; n < 6; n++) check("t4_alternate", ord[n], (n % 2 == 0) ? 3 : 1);

    // 5: reset during WAIT for channel 2, then a fresh conversion
    set_val(2, 678);
    req = 4'b0100;
    wait_flash(50, t_flash);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_bcd_clear", bcd_out, '0);
    check("t5_flash", cvt_flash, 0);
    wait_done(4'b0100, 50, ch);
    req = '0;
    check("t5_bcd", bcd_out[35:24], 12'h678);

    // 6: channel 0 drops req during WAIT
    set_val(0, 456);
    req = 4'b0001;
    wait_flash(50, t_flash);
    repeat (3) step();
    req = '0;
    wait_done(4'b0001, 50, ch);
    check("t6_bcd", bcd_out[11:0], 12'h456);
    n_fl = 0;
    repeat (20) begin
      step();
      if (cvt_flash) n_fl++;
    end
    check("t6_no_regrant", n_fl, 0);

    // 7: randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      step();
      rst = ($urandom_range(0, 799) == 0);
      for (int k = 0; k < N_CH; k++) begin
        if (req[k] && done[k] && $urandom_range(0, 1) == 1)
          req[k] = 1'b0;
        else if (req[k] && $urandom_range(0, 99) == 0)
          req[k] = 1'b0;
        else if (!req[k] && $urandom_range(0, 7) == 0) begin
          req[k] = 1'b1;
          set_val(k, rand_val());
        end else if ($urandom_range(0, 15) == 0)
          set_val(k, rand_val());
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (CVT_LAT + 6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
